// File: rtl/score_stream_tx.sv
// Transmit side of the softmax score stream: buffers a vector of signed Q8.8 scores, then
// presents them one per cycle with a valid qualifier and a held end-of-input flag.
module score_stream_tx #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AW         = 4,
  parameter int unsigned END_CYCLES = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_wr_en,
  input  logic [2*WIDTH-1:0]   i_wr_data,
  input  logic                 i_start,
  input  logic                 i_out_ready,
  output logic [2*WIDTH-1:0]   o_number,
  output logic                 o_number_valid,
  output logic                 o_end_of_input_flag,
  output logic                 o_busy,
  output logic [AW:0]          o_count,
  output logic                 o_full,
  output logic                 o_wr_err,
  output logic                 o_done
);

  localparam int unsigned DW = 2 * WIDTH;
  localparam int unsigned EW = (END_CYCLES > 1) ? $clog2(END_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StEnd
  } state_e;

  state_e          r_state;
  logic [DW-1:0]   r_mem [DEPTH];
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic [EW-1:0]   r_end_cnt;
  logic [DW-1:0]   r_number;
  logic            r_valid;
  logic            r_eoi;
  logic            r_wr_err;
  logic            r_done;

  logic            w_full;
  logic            w_wr_accept;
  logic            w_last;
  logic            w_end_last;
  logic [AW-1:0]   w_rd_next;

  assign w_full      = (r_count == (AW+1)'(DEPTH));
  // A simultaneous start always wins over a write.
  assign w_wr_accept = !i_reset && (r_state == StIdle) && i_wr_en && !i_start && !w_full;
  assign w_last      = ({1'b0, r_rd_ptr} == (r_count - (AW+1)'(1)));
  assign w_end_last  = (r_end_cnt == EW'(END_CYCLES - 1));
  assign w_rd_next   = r_rd_ptr + AW'(1);

  // Score storage carries no reset; contents are only read below the write pointer.
  always_ff @(posedge i_clk) begin
    if (w_wr_accept) begin
      r_mem[r_count[AW-1:0]] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= StIdle;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_end_cnt <= '0;
      r_number  <= '0;
      r_valid   <= 1'b0;
      r_eoi     <= 1'b0;
      r_wr_err  <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_wr_err <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        StIdle: begin
          if (i_start) begin
            if (r_count != '0) begin
              r_state  <= StStream;
              r_rd_ptr <= '0;
              r_number <= r_mem[0];
              r_valid  <= 1'b1;
              r_wr_err <= i_wr_en;
            end else begin
              r_wr_err <= 1'b1;
            end
          end else if (i_wr_en) begin
            if (w_full) begin
              r_wr_err <= 1'b1;
            end else begin
              r_count <= r_count + (AW+1)'(1);
            end
          end
        end
        StStream: begin
          r_wr_err <= i_wr_en;
          if (i_out_ready) begin
            if (w_last) begin
              // Number keeps the last score through the end phase.
              r_state   <= StEnd;
              r_valid   <= 1'b0;
              r_eoi     <= 1'b1;
              r_end_cnt <= '0;
            end else begin
              r_rd_ptr <= w_rd_next;
              r_number <= r_mem[w_rd_next];
            end
          end
        end
        StEnd: begin
          r_wr_err <= i_wr_en;
          if (w_end_last) begin
            r_state   <= StIdle;
            r_eoi     <= 1'b0;
            r_done    <= 1'b1;
            r_count   <= '0;
            r_end_cnt <= '0;
          end else begin
            r_end_cnt <= r_end_cnt + EW'(1);
          end
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_number            = r_number;
  assign o_number_valid      = r_valid;
  assign o_end_of_input_flag = r_eoi;
  assign o_busy              = (r_state != StIdle);
  assign o_count             = r_count;
  assign o_full              = w_full;
  assign o_wr_err            = r_wr_err;
  assign o_done              = r_done;

endmodule
